curve_contrast_lut_ctrl: RTL and testbench
==========================================

// Module: curve_contrast_lut_ctrl
// PURPOSE
//  Frame-synchronous controller for the pixel contrast-curve lookup on the Y (luma) stream.
//  Holds two 256x8 curve banks: one active, one shadow. A host loads the shadow bank over a valid/ready port.
//  The banks swap only on a frame boundary, so one frame never mixes two curves.
//  Sits in the vip chain between the YCbCr converter and the downstream Y-channel filters.
// PARAMETERS
//  DATA_W     8  pixel/curve entry width (LUT depth = 2**DATA_W)
//  VSYNC_POL  1  active level of per_frame_vsync; frame start = transition into active level
// PORTS
//  clk              in   1       pixel clock; the only clock
//  rst              in   1       asynchronous, active-high reset
//  cfg_wr_valid     in   1       shadow-bank write request
//  cfg_wr_ready     out  1       write accepted when valid&ready
//  cfg_wr_addr      in   DATA_W  curve index (input grey level)
//  cfg_wr_data      in   DATA_W  curve output value
//  cfg_commit       in   1       1-cycle pulse: request swap at next frame start
//  cfg_bypass       in   1       1 = output Y unchanged; sampled at frame start only
//  busy             out  1       swap pending (or init running)
//  swap_done        out  1       1-cycle pulse on the cycle after the bank swap
//  per_frame_vsync  in   1       input frame sync
//  per_frame_href   in   1       input line valid
//  per_frame_clken  in   1       input pixel valid
//  per_img_Y        in   DATA_W  input luma
//  post_frame_vsync out  1       vsync delayed 2 cycles
//  post_frame_href  out  1       href delayed 2 cycles
//  post_frame_clken out  1       clken delayed 2 cycles
//  post_img_Y       out  DATA_W  curve(per_img_Y), or bypassed Y, delayed 2 cycles
// BEHAVIOUR
//  Reset values: all post_* = 0; cfg_wr_ready = 1; busy = 0; swap_done = 0; active_bank = 0.
//   Also bypass_r = 1, curve_valid = 0, FSM = S_IDLE (S_INIT with macro).
//  Datapath:
//   - Cycle 0: synchronous read of active bank at per_img_Y; sideband and Y registered.
//   - Cycle 1: mux LUT/bypass into post_img_Y.
//   - Fixed latency 2; no stalls; the pipeline advances every clk regardless of clken.
//  Effective bypass = bypass_r | ~curve_valid. Bypass output = per_img_Y delayed 2.
//  Frame start = vsync edge into VSYNC_POL level, detected with 1 registered vsync sample.
//   On that cycle bypass_r <= cfg_bypass.
//  FSM:
//   - S_IDLE: cfg_wr_ready=1; accepted writes go to the shadow bank (~active_bank).
//     cfg_commit -> S_PENDING.
//   - S_PENDING: cfg_wr_ready=0, busy=1; further commits ignored.
//     On frame start: active_bank flips, curve_valid <= 1, swap_done pulses next cycle, -> S_IDLE.
//  Boundary rules:
//   - Commit on the same cycle as a frame start: the swap waits for the following frame start.
//   - Commit and write in the same cycle: the write lands, then commit is taken.
//   - After a swap the new shadow holds the previous curve; the host reloads all 256 entries before the next commit.
//   - Pixels in flight at the swap edge (2 cycles) use the old bank; acceptable, they fall in vsync blanking.
//   - Reset mid-frame or mid-pending: immediate return to reset values; a pending commit is lost.
//   - Bank RAM contents are not reset.
//   - Repeated writes to one address: last write wins.
// CONFIGURATION
//  Macro CURVE_LUT_IDENTITY_INIT_EN:
//   - Defined: after reset the FSM enters S_INIT and writes identity (addr->addr) into both banks, 1 entry/cycle, 256 cycles.
//     During S_INIT: busy=1, cfg_wr_ready=0, commits ignored.
//     On exit: curve_valid=1 -> S_IDLE. bypass_r is still 1 until the first frame start samples cfg_bypass.
//   - Undefined: no S_INIT; curve_valid=0 until the first swap, so output = bypassed Y.
// STRUCTURE
//  Package curve_ctrl_pkg: DATA_W default, LUT_DEPTH, state enum {S_INIT,S_IDLE,S_PENDING}.
//  Sub-module curve_lut_bank_ram: 2 x LUT_DEPTH x DATA_W.
//   - One write port: bank, addr, data.
//   - One registered read port: bank, addr.
//   - Inferred BSRAM.
//  Top: FSM, frame-start detect, sideband delay line, output mux.
// TESTING
//  1. Reset, no macro, Y ramp 0..255 with clken -> post_img_Y = Y exactly 2 cycles later. Sideband matches, delayed 2.
//  2. Load inverse curve (data=255-addr), commit mid-frame -> busy=1, ready=0. At next vsync edge swap_done pulses.
//     Next frame Y=0x10 -> 0xEF; current frame stays bypassed.
//  3. Commit on the exact frame-start cycle -> no swap this frame; swap at the following frame start.
//  4. cfg_bypass=1 toggled mid-frame with valid curve -> output changes only from next frame. Y=0x40 -> 0x40.
//  5. Assert rst during S_PENDING -> busy=0, ready=1, post_*=0 same cycle. Later frames bypassed; no swap_done.
//  6. With CURVE_LUT_IDENTITY_INIT_EN: busy high for 256 cycles after reset, ready=0.
//     Writes rejected; then Y=0xA5 -> 0xA5 via LUT path.

Source files
------------

// File: rtl/curve_ctrl_pkg.sv
// Shared types and constants for the luma contrast-curve LUT controller.
// Build option CURVE_LUT_IDENTITY_INIT_EN is consumed by curve_contrast_lut_ctrl.
package curve_ctrl_pkg;

    localparam int CURVE_DATA_W = 8;
    localparam int LUT_DEPTH    = 2 ** CURVE_DATA_W;

    typedef enum logic [1:0] {
        S_INIT    = 2'd0,
        S_IDLE    = 2'd1,
        S_PENDING = 2'd2
    } state_e;

endpackage

// File: rtl/curve_lut_bank_ram.sv
// Two curve banks behind one masked write port and one registered read port.
// No reset on the storage so it maps onto block RAM.
module curve_lut_bank_ram
    import curve_ctrl_pkg::*;
#(
    parameter int DATA_W = CURVE_DATA_W
) (
    input  logic              clk,
    input  logic [1:0]        wr_en,
    input  logic [DATA_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_bank,
    input  logic [DATA_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int DEPTH = 2 ** DATA_W;

    logic [DATA_W-1:0] bank0_mem [DEPTH];
    logic [DATA_W-1:0] bank1_mem [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    // wr_en is a per-bank mask so identity init can fill both banks at once
    always_ff @(posedge clk) begin
        if (wr_en[0]) bank0_mem[wr_addr] <= wr_data;
        if (wr_en[1]) bank1_mem[wr_addr] <= wr_data;
        rd_data_q <= rd_bank ? bank1_mem[rd_addr] : bank0_mem[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/curve_contrast_lut_ctrl.sv
// Frame-synchronous double-buffered contrast curve on the Y stream, latency 2.
// Define CURVE_LUT_IDENTITY_INIT_EN to fill both banks with identity after reset.
module curve_contrast_lut_ctrl
    import curve_ctrl_pkg::*;
#(
    parameter int   DATA_W    = CURVE_DATA_W,
    parameter logic VSYNC_POL = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_wr_valid,
    output logic              cfg_wr_ready,
    input  logic [DATA_W-1:0] cfg_wr_addr,
    input  logic [DATA_W-1:0] cfg_wr_data,
    input  logic              cfg_commit,
    input  logic              cfg_bypass,
    output logic              busy,
    output logic              swap_done,
    input  logic              per_frame_vsync,
    input  logic              per_frame_href,
    input  logic              per_frame_clken,
    input  logic [DATA_W-1:0] per_img_Y,
    output logic              post_frame_vsync,
    output logic              post_frame_href,
    output logic              post_frame_clken,
    output logic [DATA_W-1:0] post_img_Y
);

`ifdef CURVE_LUT_IDENTITY_INIT_EN
    localparam state_e RST_STATE = S_INIT;
`else
    localparam state_e RST_STATE = S_IDLE;
`endif

    state_e            state_q, state_d;
    logic              active_bank_q, active_bank_d;
    logic              curve_valid_q, curve_valid_d;
    logic              bypass_q, bypass_d;
    logic              vsync_q, vsync_d;
    logic              swap_done_q, swap_done_d;
    logic              vs1_q, vs1_d, hr1_q, hr1_d, ce1_q, ce1_d;
    logic [DATA_W-1:0] y1_q, y1_d;
    logic              vs2_q, vs2_d, hr2_q, hr2_d, ce2_q, ce2_d;
    logic [DATA_W-1:0] y2_q, y2_d;

    logic              frame_start;
    logic              swap;
    logic              init_last;
    logic              wr_fire;
    logic [1:0]        ram_wr_en;
    logic [DATA_W-1:0] ram_wr_addr;
    logic [DATA_W-1:0] ram_wr_data;
    logic [DATA_W-1:0] lut_q;

    assign frame_start = (per_frame_vsync == VSYNC_POL) && (vsync_q != VSYNC_POL);
    assign swap        = (state_q == S_PENDING) && frame_start;
    assign wr_fire     = cfg_wr_valid && cfg_wr_ready;

`ifdef CURVE_LUT_IDENTITY_INIT_EN
    logic [DATA_W-1:0] init_cnt_q, init_cnt_d;

    assign init_last = (state_q == S_INIT) && (init_cnt_q == '1);

    always_comb begin
        init_cnt_d = '0;
        if (state_q == S_INIT) init_cnt_d = init_cnt_q + DATA_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) init_cnt_q <= '0;
        else     init_cnt_q <= init_cnt_d;
    end

    always_comb begin
        ram_wr_en   = 2'b00;
        ram_wr_addr = cfg_wr_addr;
        ram_wr_data = cfg_wr_data;
        if (state_q == S_INIT) begin
            ram_wr_en   = 2'b11;
            ram_wr_addr = init_cnt_q;
            ram_wr_data = init_cnt_q;
        end else if (wr_fire) begin
            ram_wr_en = active_bank_q ? 2'b01 : 2'b10;
        end
    end
`else
    assign init_last = 1'b0;

    always_comb begin
        ram_wr_en   = 2'b00;
        ram_wr_addr = cfg_wr_addr;
        ram_wr_data = cfg_wr_data;
        if (wr_fire) ram_wr_en = active_bank_q ? 2'b01 : 2'b10;
    end
`endif

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= RST_STATE;
        else     state_q <= state_d;
    end

    // next state; a commit seen on a frame-start cycle waits a whole frame
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_INIT:    if (init_last) state_d = S_IDLE;
            S_IDLE:    if (cfg_commit) state_d = S_PENDING;
            S_PENDING: if (frame_start) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        cfg_wr_ready = (state_q == S_IDLE);
        busy         = (state_q != S_IDLE);
    end

    always_comb begin
        active_bank_d = active_bank_q ^ swap;
        curve_valid_d = curve_valid_q | swap | init_last;
        bypass_d      = frame_start ? cfg_bypass : bypass_q;
        vsync_d       = per_frame_vsync;
        swap_done_d   = swap;
        vs1_d         = per_frame_vsync;
        hr1_d         = per_frame_href;
        ce1_d         = per_frame_clken;
        y1_d          = per_img_Y;
        vs2_d         = vs1_q;
        hr2_d         = hr1_q;
        ce2_d         = ce1_q;
        y2_d          = (bypass_q || !curve_valid_q) ? y1_q : lut_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_bank_q <= 1'b0;
            curve_valid_q <= 1'b0;
            bypass_q      <= 1'b1;
            vsync_q       <= !VSYNC_POL;
            swap_done_q   <= 1'b0;
            vs1_q         <= 1'b0;
            hr1_q         <= 1'b0;
            ce1_q         <= 1'b0;
            y1_q          <= '0;
            vs2_q         <= 1'b0;
            hr2_q         <= 1'b0;
            ce2_q         <= 1'b0;
            y2_q          <= '0;
        end else begin
            active_bank_q <= active_bank_d;
            curve_valid_q <= curve_valid_d;
            bypass_q      <= bypass_d;
            vsync_q       <= vsync_d;
            swap_done_q   <= swap_done_d;
            vs1_q         <= vs1_d;
            hr1_q         <= hr1_d;
            ce1_q         <= ce1_d;
            y1_q          <= y1_d;
            vs2_q         <= vs2_d;
            hr2_q         <= hr2_d;
            ce2_q         <= ce2_d;
            y2_q          <= y2_d;
        end
    end

    curve_lut_bank_ram #(
        .DATA_W (DATA_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (ram_wr_en),
        .wr_addr (ram_wr_addr),
        .wr_data (ram_wr_data),
        .rd_bank (active_bank_q),
        .rd_addr (per_img_Y),
        .rd_data (lut_q)
    );

    assign swap_done        = swap_done_q;
    assign post_frame_vsync = vs2_q;
    assign post_frame_href  = hr2_q;
    assign post_frame_clken = ce2_q;
    assign post_img_Y       = y2_q;

endmodule

// File: tb/tb_curve_contrast_lut_ctrl.sv
// Randomized bench for curve_contrast_lut_ctrl against a curve/frame-level model.
// Also covers the CURVE_LUT_IDENTITY_INIT_EN build when that macro is defined.
module tb_curve_contrast_lut_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_wr_valid = 1'b0;
    logic       cfg_wr_ready;
    logic [7:0] cfg_wr_addr = '0;
    logic [7:0] cfg_wr_data = '0;
    logic       cfg_commit = 1'b0;
    logic       cfg_bypass = 1'b0;
    logic       busy;
    logic       swap_done;
    logic       vs = 1'b0;
    logic       hr = 1'b0;
    logic       ce = 1'b0;
    logic [7:0] y = '0;
    logic       post_frame_vsync;
    logic       post_frame_href;
    logic       post_frame_clken;
    logic [7:0] post_img_Y;

    always #5 clk = ~clk;

    curve_contrast_lut_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .cfg_wr_valid     (cfg_wr_valid),
        .cfg_wr_ready     (cfg_wr_ready),
        .cfg_wr_addr      (cfg_wr_addr),
        .cfg_wr_data      (cfg_wr_data),
        .cfg_commit       (cfg_commit),
        .cfg_bypass       (cfg_bypass),
        .busy             (busy),
        .swap_done        (swap_done),
        .per_frame_vsync  (vs),
        .per_frame_href   (hr),
        .per_frame_clken  (ce),
        .per_img_Y        (y),
        .post_frame_vsync (post_frame_vsync),
        .post_frame_href  (post_frame_href),
        .post_frame_clken (post_frame_clken),
        .post_img_Y       (post_img_Y)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // model: the curve on screen, the curve being loaded, and frame flags
    typedef struct packed {
        logic       vs;
        logic       hr;
        logic       ce;
        logic [7:0] y;
    } px_t;

    int  act_curve [256];
    int  shd_curve [256];
    bit  m_valid, m_pend, m_byp, m_prev_vs, m_swap;
    int  m_init;
    px_t d1, d2;

    task automatic model_reset();
        m_valid   = 0;
        m_pend    = 0;
        m_byp     = 1;
        m_prev_vs = 0;
        m_swap    = 0;
        d1        = '0;
        d2        = '0;
`ifdef CURVE_LUT_IDENTITY_INIT_EN
        m_init = 256;
`else
        m_init = 0;
`endif
    endtask

    task automatic model_edge();
        bit  fs;
        bit  busy_pre;
        px_t np;
        int  t;
        fs       = vs && !m_prev_vs;
        busy_pre = m_pend || (m_init > 0);
        np.vs = vs;
        np.hr = hr;
        np.ce = ce;
        np.y  = (m_byp || !m_valid) ? y : 8'(act_curve[y]);
        if (cfg_wr_valid && !busy_pre) shd_curve[cfg_wr_addr] = cfg_wr_data;
        m_swap = 0;
        if (m_init > 0) begin
            m_init--;
            if (m_init == 0) begin
                m_valid = 1;
                for (int i = 0; i < 256; i++) begin
                    act_curve[i] = i;
                    shd_curve[i] = i;
                end
            end
        end else if (m_pend) begin
            if (fs) begin
                for (int i = 0; i < 256; i++) begin
                    t            = act_curve[i];
                    act_curve[i] = shd_curve[i];
                    shd_curve[i] = t;
                end
                m_valid = 1;
                m_pend  = 0;
                m_swap  = 1;
            end
        end else if (cfg_commit) begin
            m_pend = 1;
        end
        if (fs) m_byp = cfg_bypass;
        m_prev_vs = vs;
        d2 = d1;
        d1 = np;
    endtask

    task automatic check_all();
        chk("post_vsync", post_frame_vsync, d2.vs);
        chk("post_href", post_frame_href, d2.hr);
        chk("post_clken", post_frame_clken, d2.ce);
        if (d2.ce) chk("post_Y", post_img_Y, d2.y);
        chk("busy", busy, m_pend || (m_init > 0));
        chk("ready", cfg_wr_ready, !(m_pend || (m_init > 0)));
        chk("swap_done", swap_done, m_swap);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        cfg_commit   = 1'b0;
        cfg_wr_valid = 1'b0;
    endtask

    task automatic drive_px(input bit active);
        hr = active;
        ce = active && ($urandom % 4 != 0);
        y  = 8'($urandom);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst          = 1'b1;
        cfg_wr_valid = 1'b0;
        cfg_commit   = 1'b0;
        vs           = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("rst_post_Y", post_img_Y, 0);
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic vsync_head(input bit commit_at_fs);
        vs = 1'b1;
        drive_px(0);
        cfg_commit = commit_at_fs;
        cyc();
        repeat (2) begin
            drive_px(0);
            cyc();
        end
        vs = 1'b0;
        repeat (3) begin
            drive_px(0);
            cyc();
        end
    endtask

    task automatic frame(input int lines, input bit commit_at_fs,
                         input int byp_line, input bit byp_val);
        vsync_head(commit_at_fs);
        for (int l = 0; l < lines; l++) begin
            if (l == byp_line) cfg_bypass = byp_val;
            for (int p = 0; p < 16; p++) begin
                drive_px(1);
                if (p == 3) begin y = 8'h10; ce = 1'b1; end
                if (p == 5) begin y = 8'h40; ce = 1'b1; end
                cyc();
            end
            repeat (2) begin
                drive_px(0);
                cyc();
            end
        end
    endtask

    task automatic ramp_frame();
        vsync_head(0);
        for (int i = 0; i < 256; i++) begin
            hr = 1'b1;
            ce = 1'b1;
            y  = 8'(i);
            cyc();
        end
        repeat (3) begin
            drive_px(0);
            cyc();
        end
    endtask

    // kind 0 = inverse curve, otherwise random; optional commit with last write
    task automatic load(input int kind, input bit commit_last);
        vs = 1'b0;
        repeat (2) begin
            drive_px(1);
            cfg_wr_valid = 1'b1;
            cfg_wr_addr  = 8'h00;
            cfg_wr_data  = 8'($urandom);
            cyc();
        end
        for (int a = 0; a < 256; a++) begin
            drive_px(1);
            cfg_wr_valid = 1'b1;
            cfg_wr_addr  = 8'(a);
            cfg_wr_data  = (kind == 0) ? 8'(255 - a) : 8'($urandom);
            cfg_commit   = commit_last && (a == 255);
            cyc();
        end
    endtask

    task automatic pending_pokes(input int n);
        repeat (n) begin
            drive_px(1);
            cfg_wr_valid = 1'b1;
            cfg_wr_addr  = 8'($urandom);
            cfg_wr_data  = 8'($urandom);
            cfg_commit   = ($urandom % 2 == 0);
            cyc();
        end
    endtask

    initial begin
        reset_dut();
`ifdef CURVE_LUT_IDENTITY_INIT_EN
        for (int i = 0; i < 260; i++) begin
            drive_px(1);
            cfg_wr_valid = 1'b1;
            cfg_wr_addr  = 8'($urandom);
            cfg_wr_data  = 8'($urandom);
            cfg_commit   = (i < 250) && ($urandom % 8 == 0);
            cyc();
        end
        y = 8'hA5;
        ce = 1'b1;
        hr = 1'b1;
        cyc();
`endif
        ramp_frame();
        frame(2, 0, -1, 0);
        load(0, 1);
        pending_pokes(6);
        frame(2, 0, -1, 0);
        frame(2, 0, -1, 0);
        load(1, 0);
        frame(2, 1, -1, 0);
        frame(2, 0, -1, 0);
        frame(2, 0, -1, 0);
        frame(3, 0, 1, 1);
        frame(2, 0, -1, 0);
        frame(2, 0, 1, 0);
        frame(2, 0, -1, 0);
        load(1, 1);
        pending_pokes(3);
        reset_dut();
        frame(2, 0, -1, 0);
        frame(2, 0, -1, 0);
        ramp_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
